// File: rtl/demux_vc.sv
// demux_vc: receive-side two-VC demultiplexer. Registers the serialized word stream,
// routes each word by its select bit, and gives each VC a 2-entry skid buffer plus stats.
module demux_vc #(
    parameter int DATA_SIZE = 6,
    parameter int SEL_BIT   = 4,
    parameter int CNT_SIZE  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_demux_d,
    input  logic [DATA_SIZE-1:0] data_demux_d,
    input  logic                 full_vc0,
    input  logic                 full_vc1,
    output logic                 push_vc0,
    output logic [DATA_SIZE-1:0] data_vc0,
    output logic                 push_vc1,
    output logic [DATA_SIZE-1:0] data_vc1,
    output logic                 pause_vc0,
    output logic                 pause_vc1,
    output logic [CNT_SIZE-1:0]  count_vc0,
    output logic [CNT_SIZE-1:0]  count_vc1,
    output logic [CNT_SIZE-1:0]  drop_count
);

    localparam int NUM_VC = 2;

    logic                 in_valid_q;
    logic [DATA_SIZE-1:0] in_data_q;
    logic                 vc;

    logic [NUM_VC-1:0]    full;
    logic [DATA_SIZE-1:0] buf_mem   [NUM_VC][2];
    logic [1:0]           buf_cnt   [NUM_VC];
    logic [NUM_VC-1:0]    push_q;
    logic [DATA_SIZE-1:0] data_q    [NUM_VC];
    logic [CNT_SIZE-1:0]  count_q   [NUM_VC];
    logic [CNT_SIZE-1:0]  drop_q;

    logic [NUM_VC-1:0]    in_hit;
    logic [NUM_VC-1:0]    do_push;
    logic [NUM_VC-1:0]    pop;
    logic [NUM_VC-1:0]    bypass;
    logic [NUM_VC-1:0]    store;
    logic [NUM_VC-1:0]    drop;
    logic [DATA_SIZE-1:0] cand      [NUM_VC];
    logic [1:0]           cnt_after_pop [NUM_VC];

    assign full = {full_vc1, full_vc0};
    assign vc   = in_data_q[SEL_BIT];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_valid_q <= 1'b0;
            in_data_q  <= '0;
        end else begin
            in_valid_q <= valid_demux_d;
            in_data_q  <= data_demux_d;
        end
    end

    // The buffer head always has priority over the registered word so per-VC order holds;
    // a word that cannot bypass goes to the tail if the head pop left room, else it is lost.
    always_comb begin
        for (int n = 0; n < NUM_VC; n++) begin
            in_hit[n]        = in_valid_q && (vc == 1'(n));
            cand[n]          = (buf_cnt[n] != 2'd0) ? buf_mem[n][0] : in_data_q;
            do_push[n]       = ((buf_cnt[n] != 2'd0) || in_hit[n]) && !full[n];
            pop[n]           = do_push[n] && (buf_cnt[n] != 2'd0);
            cnt_after_pop[n] = buf_cnt[n] - {1'b0, pop[n]};
            bypass[n]        = do_push[n] && (buf_cnt[n] == 2'd0);
            store[n]         = in_hit[n] && !bypass[n] && (cnt_after_pop[n] != 2'd2);
            drop[n]          = in_hit[n] && !bypass[n] && (cnt_after_pop[n] == 2'd2);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < NUM_VC; n++) begin
                buf_mem[n][0] <= '0;
                buf_mem[n][1] <= '0;
                buf_cnt[n]    <= 2'd0;
                push_q[n]     <= 1'b0;
                data_q[n]     <= '0;
                count_q[n]    <= '0;
            end
        end else begin
            for (int n = 0; n < NUM_VC; n++) begin
                push_q[n] <= do_push[n];
                if (do_push[n]) begin
                    data_q[n]  <= cand[n];
                    count_q[n] <= count_q[n] + CNT_SIZE'(1);
                end
                if (pop[n]) begin
                    buf_mem[n][0] <= buf_mem[n][1];
                end
                // Tail write is placed after the shift so a store into slot 0 wins on a pop.
                if (store[n]) begin
                    buf_mem[n][cnt_after_pop[n][0]] <= in_data_q;
                end
                buf_cnt[n] <= cnt_after_pop[n] + {1'b0, store[n]};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_q <= '0;
        end else if ((|drop) && (drop_q != {CNT_SIZE{1'b1}})) begin
            drop_q <= drop_q + CNT_SIZE'(1);
        end
    end

    assign push_vc0   = push_q[0];
    assign push_vc1   = push_q[1];
    assign data_vc0   = data_q[0];
    assign data_vc1   = data_q[1];
    assign count_vc0  = count_q[0];
    assign count_vc1  = count_q[1];
    assign drop_count = drop_q;
    assign pause_vc0  = (buf_cnt[0] != 2'd0) | full_vc0;
    assign pause_vc1  = (buf_cnt[1] != 2'd0) | full_vc1;

endmodule

// File: tb/tb_demux_vc.sv
// tb_demux_vc: directed and randomized checks of demux_vc against a queue-based
// reference model of the routing, skid-buffer, pause and counter rules.
module tb_demux_vc;

    logic       clk;
    logic       reset;
    logic       valid_demux_d;
    logic [5:0] data_demux_d;
    logic       full_vc0;
    logic       full_vc1;
    logic       push_vc0;
    logic [5:0] data_vc0;
    logic       push_vc1;
    logic [5:0] data_vc1;
    logic       pause_vc0;
    logic       pause_vc1;
    logic [7:0] count_vc0;
    logic [7:0] count_vc1;
    logic [7:0] drop_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: registered input word plus one word queue per VC.
    logic       m_in_valid;
    logic [5:0] m_in_data;
    logic [5:0] q0[$];
    logic [5:0] q1[$];
    logic       m_push0, m_push1;
    logic [5:0] m_data0, m_data1;
    int         m_cnt0, m_cnt1, m_drop;

    demux_vc #(.DATA_SIZE(6), .SEL_BIT(4), .CNT_SIZE(8)) dut (
        .clk(clk), .reset(reset),
        .valid_demux_d(valid_demux_d), .data_demux_d(data_demux_d),
        .full_vc0(full_vc0), .full_vc1(full_vc1),
        .push_vc0(push_vc0), .data_vc0(data_vc0),
        .push_vc1(push_vc1), .data_vc1(data_vc1),
        .pause_vc0(pause_vc0), .pause_vc1(pause_vc1),
        .count_vc0(count_vc0), .count_vc1(count_vc1),
        .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_in_valid = 1'b0; m_in_data = '0;
        q0.delete(); q1.delete();
        m_push0 = 1'b0; m_push1 = 1'b0; m_data0 = '0; m_data1 = '0;
        m_cnt0 = 0; m_cnt1 = 0; m_drop = 0;
    endtask

    task automatic model_drop();
        if (m_drop < 255) m_drop++;
    endtask

    // One clock edge of the behavioural model, using the inputs sampled at that edge.
    task automatic model_edge(input logic v, input logic [5:0] d, input logic f0, input logic f1);
        logic hit0, hit1;
        hit0 = m_in_valid && !m_in_data[4];
        hit1 = m_in_valid &&  m_in_data[4];
        m_push0 = 1'b0;
        m_push1 = 1'b0;
        if (q0.size() > 0) begin
            if (!f0) begin m_push0 = 1'b1; m_data0 = q0.pop_front(); m_cnt0 = (m_cnt0 + 1) % 256; end
            if (hit0) begin if (q0.size() < 2) q0.push_back(m_in_data); else model_drop(); end
        end else if (hit0) begin
            if (!f0) begin m_push0 = 1'b1; m_data0 = m_in_data; m_cnt0 = (m_cnt0 + 1) % 256; end
            else q0.push_back(m_in_data);
        end
        if (q1.size() > 0) begin
            if (!f1) begin m_push1 = 1'b1; m_data1 = q1.pop_front(); m_cnt1 = (m_cnt1 + 1) % 256; end
            if (hit1) begin if (q1.size() < 2) q1.push_back(m_in_data); else model_drop(); end
        end else if (hit1) begin
            if (!f1) begin m_push1 = 1'b1; m_data1 = m_in_data; m_cnt1 = (m_cnt1 + 1) % 256; end
            else q1.push_back(m_in_data);
        end
        m_in_valid = v;
        m_in_data  = d;
    endtask

    task automatic cycle(input logic v, input logic [5:0] d, input logic f0, input logic f1);
        valid_demux_d = v; data_demux_d = d; full_vc0 = f0; full_vc1 = f1;
        @(posedge clk);
        model_edge(v, d, f0, f1);
        #1;
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        model_reset();
        #4 reset = 1'b0;
    endtask

    task automatic test_reset();
        cycle(1'b1, 6'h05, 1'b0, 1'b0);
        cycle(1'b1, 6'h13, 1'b0, 1'b0);
        cycle(1'b1, 6'h01, 1'b1, 1'b0);
        cycle(1'b1, 6'h02, 1'b1, 1'b0);
        valid_demux_d = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_checks++; if (push_vc0 !== 1'b0) $display("[TB] FAIL reset_push0 got %b exp 0", push_vc0); else n_pass++;
        n_checks++; if (data_vc0 !== 6'h00) $display("[TB] FAIL reset_data0 got %h exp 00", data_vc0); else n_pass++;
        n_checks++; if (push_vc1 !== 1'b0) $display("[TB] FAIL reset_push1 got %b exp 0", push_vc1); else n_pass++;
        n_checks++; if (data_vc1 !== 6'h00) $display("[TB] FAIL reset_data1 got %h exp 00", data_vc1); else n_pass++;
        n_checks++; if (count_vc0 !== 8'd0) $display("[TB] FAIL reset_count0 got %0d exp 0", count_vc0); else n_pass++;
        n_checks++; if (count_vc1 !== 8'd0) $display("[TB] FAIL reset_count1 got %0d exp 0", count_vc1); else n_pass++;
        n_checks++; if (drop_count !== 8'd0) $display("[TB] FAIL reset_drop got %0d exp 0", drop_count); else n_pass++;
        n_checks++; if (pause_vc0 !== 1'b1) $display("[TB] FAIL reset_pause0 got %b exp 1", pause_vc0); else n_pass++;
        n_checks++; if (pause_vc1 !== 1'b0) $display("[TB] FAIL reset_pause1 got %b exp 0", pause_vc1); else n_pass++;
        model_reset();
        #3 reset = 1'b0;
        cycle(1'b0, 6'h00, 1'b0, 1'b0);
        n_checks++; if (push_vc0 !== 1'b0) $display("[TB] FAIL reset_nopush0 got %b exp 0", push_vc0); else n_pass++;
        n_checks++; if (pause_vc0 !== 1'b0) $display("[TB] FAIL reset_flushed_pause0 got %b exp 0", pause_vc0); else n_pass++;
    endtask

    task automatic test_basic_routing();
        cycle(1'b1, 6'h05, 1'b0, 1'b0);
        cycle(1'b1, 6'h13, 1'b0, 1'b0);
        n_checks++; if (push_vc0 !== 1'b1) $display("[TB] FAIL basic_push0 got %b exp 1", push_vc0); else n_pass++;
        n_checks++; if (data_vc0 !== 6'h05) $display("[TB] FAIL basic_data0 got %h exp 05", data_vc0); else n_pass++;
        n_checks++; if (push_vc1 !== 1'b0) $display("[TB] FAIL basic_early_push1 got %b exp 0", push_vc1); else n_pass++;
        cycle(1'b0, 6'h00, 1'b0, 1'b0);
        n_checks++; if (push_vc1 !== 1'b1) $display("[TB] FAIL basic_push1 got %b exp 1", push_vc1); else n_pass++;
        n_checks++; if (data_vc1 !== 6'h13) $display("[TB] FAIL basic_data1 got %h exp 13", data_vc1); else n_pass++;
        n_checks++; if (push_vc0 !== 1'b0) $display("[TB] FAIL basic_push0_off got %b exp 0", push_vc0); else n_pass++;
        n_checks++; if (count_vc0 !== 8'd1) $display("[TB] FAIL basic_count0 got %0d exp 1", count_vc0); else n_pass++;
        n_checks++; if (count_vc1 !== 8'd1) $display("[TB] FAIL basic_count1 got %0d exp 1", count_vc1); else n_pass++;
    endtask

    task automatic test_backpressure();
        cycle(1'b1, 6'h01, 1'b1, 1'b0);
        cycle(1'b1, 6'h02, 1'b1, 1'b0);
        n_checks++; if (push_vc0 !== 1'b0) $display("[TB] FAIL bp_hold_a got %b exp 0", push_vc0); else n_pass++;
        cycle(1'b0, 6'h00, 1'b1, 1'b0);
        n_checks++; if (push_vc0 !== 1'b0) $display("[TB] FAIL bp_hold_b got %b exp 0", push_vc0); else n_pass++;
        n_checks++; if (pause_vc0 !== 1'b1) $display("[TB] FAIL bp_pause got %b exp 1", pause_vc0); else n_pass++;
        cycle(1'b0, 6'h00, 1'b0, 1'b0);
        n_checks++; if (pause_vc0 !== 1'b1) $display("[TB] FAIL bp_pause_one_left got %b exp 1", pause_vc0); else n_pass++;
        n_checks++; if ({push_vc0, data_vc0} !== {1'b1, 6'h01}) $display("[TB] FAIL bp_first got %b/%h exp 1/01", push_vc0, data_vc0); else n_pass++;
        cycle(1'b0, 6'h00, 1'b0, 1'b0);
        n_checks++; if ({push_vc0, data_vc0} !== {1'b1, 6'h02}) $display("[TB] FAIL bp_second got %b/%h exp 1/02", push_vc0, data_vc0); else n_pass++;
        n_checks++; if (pause_vc0 !== 1'b0) $display("[TB] FAIL bp_pause_clear got %b exp 0", pause_vc0); else n_pass++;
        n_checks++; if (count_vc0 !== 8'd3) $display("[TB] FAIL bp_count0 got %0d exp 3", count_vc0); else n_pass++;
    endtask

    task automatic test_overflow();
        cycle(1'b1, 6'h11, 1'b0, 1'b1);
        cycle(1'b1, 6'h12, 1'b0, 1'b1);
        cycle(1'b1, 6'h13, 1'b0, 1'b1);
        cycle(1'b0, 6'h00, 1'b0, 1'b1);
        n_checks++; if (drop_count !== 8'd1) $display("[TB] FAIL ovf_drop got %0d exp 1", drop_count); else n_pass++;
        n_checks++; if (push_vc1 !== 1'b0) $display("[TB] FAIL ovf_hold got %b exp 0", push_vc1); else n_pass++;
        cycle(1'b0, 6'h00, 1'b0, 1'b0);
        n_checks++; if ({push_vc1, data_vc1} !== {1'b1, 6'h11}) $display("[TB] FAIL ovf_first got %b/%h exp 1/11", push_vc1, data_vc1); else n_pass++;
        cycle(1'b0, 6'h00, 1'b0, 1'b0);
        n_checks++; if ({push_vc1, data_vc1} !== {1'b1, 6'h12}) $display("[TB] FAIL ovf_second got %b/%h exp 1/12", push_vc1, data_vc1); else n_pass++;
        cycle(1'b0, 6'h00, 1'b0, 1'b0);
        n_checks++; if (push_vc1 !== 1'b0) $display("[TB] FAIL ovf_no_third got %b exp 0", push_vc1); else n_pass++;
        n_checks++; if (count_vc1 !== 8'd3) $display("[TB] FAIL ovf_count1 got %0d exp 3", count_vc1); else n_pass++;
    endtask

    task automatic test_independence();
        logic [5:0] exp_d;
        for (int i = 0; i < 10; i++) begin
            cycle(i < 8, 6'h10 + 6'(i % 8), 1'b1, 1'b0);
            n_checks++; if (pause_vc1 !== 1'b0) $display("[TB] FAIL indep_pause1 cyc %0d got %b exp 0", i, pause_vc1); else n_pass++;
            if (i >= 1 && i <= 8) begin
                exp_d = 6'h10 + 6'(i - 1);
                n_checks++; if ({push_vc1, data_vc1} !== {1'b1, exp_d}) $display("[TB] FAIL indep_push1 cyc %0d got %b/%h exp 1/%h", i, push_vc1, data_vc1, exp_d); else n_pass++;
            end
        end
        n_checks++; if (count_vc1 !== 8'd11) $display("[TB] FAIL indep_count1 got %0d exp 11", count_vc1); else n_pass++;
        n_checks++; if (push_vc0 !== 1'b0) $display("[TB] FAIL indep_push0 got %b exp 0", push_vc0); else n_pass++;
    endtask

    task automatic test_counters();
        logic [5:0] d;
        do_reset();
        for (int i = 1; i <= 256; i++) begin
            d = {1'($urandom_range(0, 1)), 1'b0, 4'(i)};
            cycle(1'b1, d, 1'b0, 1'b0);
        end
        n_checks++; if (count_vc0 !== 8'd255) $display("[TB] FAIL cnt_before_wrap got %0d exp 255", count_vc0); else n_pass++;
        cycle(1'b0, 6'h00, 1'b0, 1'b0);
        n_checks++; if (count_vc0 !== 8'd0) $display("[TB] FAIL cnt_wrap got %0d exp 0", count_vc0); else n_pass++;
        for (int i = 1; i <= 310; i++) begin
            cycle(1'b1, 6'h10 | 6'($urandom_range(0, 15)), 1'b0, 1'b1);
            if (i == 100) begin
                n_checks++; if (drop_count !== 8'd97) $display("[TB] FAIL drop_mid got %0d exp 97", drop_count); else n_pass++;
            end
        end
        cycle(1'b0, 6'h00, 1'b0, 1'b1);
        n_checks++; if (drop_count !== 8'd255) $display("[TB] FAIL drop_sat got %0d exp 255", drop_count); else n_pass++;
        n_checks++; if (drop_count !== 8'(m_drop)) $display("[TB] FAIL drop_model got %0d exp %0d", drop_count, m_drop); else n_pass++;
        n_checks++; if (count_vc1 !== 8'd0) $display("[TB] FAIL drop_count1 got %0d exp 0", count_vc1); else n_pass++;
    endtask

    task automatic test_random();
        logic v, f0, f1;
        logic [5:0] d;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            d  = 6'($urandom);
            f0 = ($urandom_range(0, 9) < 3);
            f1 = ($urandom_range(0, 9) < 4);
            cycle(v, d, f0, f1);
            n_checks++;
            if ({push_vc0, data_vc0, push_vc1, data_vc1} !== {m_push0, m_data0, m_push1, m_data1})
                $display("[TB] FAIL rand_push cyc %0d got %b/%h %b/%h exp %b/%h %b/%h", i,
                         push_vc0, data_vc0, push_vc1, data_vc1, m_push0, m_data0, m_push1, m_data1);
            else n_pass++;
            n_checks++;
            if ({count_vc0, count_vc1, drop_count} !== {8'(m_cnt0), 8'(m_cnt1), 8'(m_drop)})
                $display("[TB] FAIL rand_counts cyc %0d got %0d %0d %0d exp %0d %0d %0d", i,
                         count_vc0, count_vc1, drop_count, m_cnt0, m_cnt1, m_drop);
            else n_pass++;
            n_checks++;
            if ({pause_vc0, pause_vc1} !== {(q0.size() != 0) | f0, (q1.size() != 0) | f1})
                $display("[TB] FAIL rand_pause cyc %0d got %b%b exp %b%b", i, pause_vc0, pause_vc1,
                         (q0.size() != 0) | f0, (q1.size() != 0) | f1);
            else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b1;
        valid_demux_d = 1'b0; data_demux_d = '0; full_vc0 = 1'b0; full_vc1 = 1'b0;
        model_reset();
        #12 reset = 1'b0;
        test_reset();
        test_basic_routing();
        test_backpressure();
        test_overflow();
        test_independence();
        test_counters();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog time limit reached after %0d checks", n_checks);
        $fatal(1, "[TB] watchdog");
    end

endmodule
